// File: rtl/uart_pkg.sv
// Shared UART types and helpers: parity modes, receiver FSM states, baud divisor.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_ODD,
        PAR_EVEN
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_e;

    // Clocks per bit, rounded to nearest.
    function automatic int unsigned uart_div(input int unsigned freq, input int unsigned baud);
        return (freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous input; resets to 1 (idle line level).
module sync_2ff (
    input  logic clk,
    input  logic n_reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the async input through two flops.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable width/parity/stop bits, error and
// break detection, one-word valid/ready holding register with sticky overrun.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned UART_CLK_FREQ = 24_000_000,
    parameter int unsigned UART_BAUD     = 115_200,
    parameter int unsigned DATA_BITS     = 8,
    parameter parity_e     PARITY        = PAR_NONE,
    parameter int unsigned STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_par_err,
    output logic                 m_frm_err,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 brk,
    output logic                 overrun,
    input  logic                 clr_overrun
);

    localparam int unsigned DIV  = uart_div(UART_CLK_FREQ, UART_BAUD);
    localparam int unsigned HALF = DIV / 2;
    localparam int          CW   = $clog2(DIV + 1);
    localparam int          BW   = $clog2(DATA_BITS + 1);

    logic                 rxs;
    logic                 rxs_d;
    rx_state_e            state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 stop0;
    logic                 frm_acc;

    logic                 tick;
    logic                 par_err_c;
    logic                 is_brk;
    logic                 can_load;

    sync_2ff u_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .d       (uart_rxd),
        .q       (rxs)
    );

    // Frame evaluation: sample strobe, parity check, break pattern, slot availability.
    always_comb begin
        tick      = (cnt == '0);
        par_err_c = 1'b0;
        if (PARITY != PAR_NONE)
            par_err_c = ((^shreg) ^ par_bit) != (PARITY == PAR_ODD);
        is_brk    = (shreg == '0) && ((PARITY == PAR_NONE) || !par_bit) && !stop0;
        can_load  = !m_valid || m_ready;
    end

    // Receiver FSM, bit sampling, holding register and status flags.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state     <= IDLE;
            rxs_d     <= 1'b1;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            stop0     <= 1'b1;
            frm_acc   <= 1'b0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_par_err <= 1'b0;
            m_frm_err <= 1'b0;
            brk       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rxs_d <= rxs;
            brk   <= 1'b0;
            if (m_valid && m_ready) m_valid <= 1'b0;
            if (clr_overrun)        overrun <= 1'b0;
            if (cnt != '0)          cnt     <= cnt - 1'b1;

            case (state)
                IDLE: begin
                    if (rxs_d && !rxs) begin
                        state <= START;
                        cnt   <= CW'(HALF - 1);
                    end
                end
                START: begin
                    if (tick) begin
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            cnt     <= CW'(DIV - 1);
                            bit_cnt <= '0;
                            frm_acc <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        cnt   <= CW'(DIV - 1);
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (tick) begin
                        par_bit <= rxs;
                        cnt     <= CW'(DIV - 1);
                        state   <= STOP;
                    end
                end
                STOP: begin
                    // bit_cnt reaching STOP_BITS means every stop sample is in:
                    // this is the completion cycle.
                    if (bit_cnt == BW'(STOP_BITS)) begin
                        state <= IDLE;
                        if (is_brk) begin
                            brk   <= 1'b1;
                            state <= BRK_WAIT;
                        end else if (can_load) begin
                            m_data    <= shreg;
                            m_par_err <= par_err_c;
                            m_frm_err <= frm_acc;
                            m_valid   <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (tick) begin
                        if (bit_cnt == '0) stop0 <= rxs;
                        frm_acc <= frm_acc | ~rxs;
                        bit_cnt <= bit_cnt + 1'b1;
                        cnt     <= CW'(DIV - 1);
                    end
                end
                BRK_WAIT: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench: an 8N1 receiver (A) and a 7E2 receiver (B) at DIV=16.
module tb_uart_rx_cfg;

    localparam int DIV = 16;

    typedef struct {
        int data;
        int par;
        int frm;
        bit lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       rxd_a, rxd_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       par_a, frm_a, vld_a, rdy_a, brk_a, ovr_a, clr_a;
    logic       par_b, frm_b, vld_b, rdy_b, brk_b, ovr_b, clr_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   t_start = 0;
    int   brk_cnt_a = 0;
    int   brk_cnt_b = 0;
    int   brk_before;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(
        .UART_CLK_FREQ (1_600_000),
        .UART_BAUD     (100_000),
        .DATA_BITS     (8),
        .PARITY        (uart_pkg::PAR_NONE),
        .STOP_BITS     (1)
    ) dut_a (
        .clk (clk), .n_reset (n_reset), .uart_rxd (rxd_a),
        .m_data (data_a), .m_par_err (par_a), .m_frm_err (frm_a),
        .m_valid (vld_a), .m_ready (rdy_a), .brk (brk_a),
        .overrun (ovr_a), .clr_overrun (clr_a)
    );

    uart_rx_cfg #(
        .UART_CLK_FREQ (1_600_000),
        .UART_BAUD     (100_000),
        .DATA_BITS     (7),
        .PARITY        (uart_pkg::PAR_EVEN),
        .STOP_BITS     (2)
    ) dut_b (
        .clk (clk), .n_reset (n_reset), .uart_rxd (rxd_b),
        .m_data (data_b), .m_par_err (par_b), .m_frm_err (frm_b),
        .m_valid (vld_b), .m_ready (rdy_b), .brk (brk_b),
        .overrun (ovr_b), .clr_overrun (clr_b)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic b);
        if (sel == 0) rxd_a = b;
        else          rxd_b = b;
    endtask

    // Sends n bits LSB first, DIV cycles each, then returns the line to idle.
    task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0 && sel == 0) t_start = cyc;
            drive(sel, bits[i]);
            repeat (DIV - 1) @(negedge clk);
        end
        @(negedge clk);
        drive(sel, 1'b1);
    endtask

    task automatic idle_bits(input int n);
        repeat (n * DIV) @(negedge clk);
    endtask

    function automatic logic [15:0] frame8(input logic [7:0] v, input logic s);
        return {6'b0, s, v, 1'b0};
    endfunction

    function automatic logic [15:0] frame7p(input logic [6:0] v, input logic p);
        return {5'b0, 2'b11, p, v, 1'b0};
    endfunction

    // Monitor: every accepted word is popped from its queue and compared.
    always begin
        @(negedge clk);
        #1;
        if (n_reset) begin
            if (vld_a && rdy_a) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_word", int'(data_a), -1);
                end else begin
                    ea = q_a.pop_front();
                    check("a_data", int'(data_a), ea.data);
                    check("a_par_err", int'(par_a), ea.par);
                    check("a_frm_err", int'(frm_a), ea.frm);
                    // Edge 0 is the first posedge that samples the start bit;
                    // m_valid rises 2+HALF+9*DIV+1 = 155 edges later.
                    if (ea.lat) check("a_latency", cyc - t_start, 1 + 155);
                end
            end
            if (vld_b && rdy_b) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_word", int'(data_b), -1);
                end else begin
                    eb = q_b.pop_front();
                    check("b_data", int'(data_b), eb.data);
                    check("b_par_err", int'(par_b), eb.par);
                    check("b_frm_err", int'(frm_b), eb.frm);
                end
            end
            if (brk_a) brk_cnt_a++;
            if (brk_b) brk_cnt_b++;
        end
    end

    initial begin
        n_reset = 1'b0;
        rxd_a = 1'b1; rxd_b = 1'b1;
        rdy_a = 1'b1; rdy_b = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid_a", int'(vld_a), 0);
        check("rst_data_a", int'(data_a), 0);
        check("rst_flags_a", int'({par_a, frm_a, brk_a, ovr_a}), 0);
        check("rst_valid_b", int'(vld_b), 0);
        check("rst_flags_b", int'({par_b, frm_b, brk_b, ovr_b}), 0);
        @(negedge clk);
        n_reset = 1'b1;
        idle_bits(2);

        // 8N1 0xA5 with latency check; valid must be a single-cycle pulse
        q_a.push_back('{32'hA5, 0, 0, 1'b1});
        send_bits(0, frame8(8'hA5, 1'b1), 10);
        idle_bits(1);
        check("a_valid_pulse_low", int'(vld_a), 0);

        // 7E2 0x35 (four ones): parity bit 1 is wrong, 0 is right
        q_b.push_back('{32'h35, 1, 0, 1'b0});
        send_bits(1, frame7p(7'h35, 1'b1), 11);
        idle_bits(1);
        q_b.push_back('{32'h35, 0, 0, 1'b0});
        send_bits(1, frame7p(7'h35, 1'b0), 11);
        idle_bits(1);
        q_b.push_back('{32'h4B, 0, 0, 1'b0});
        send_bits(1, frame7p(7'h4B, 1'b0), 11);
        idle_bits(1);

        // framing error: stop bit 0
        q_a.push_back('{32'h3C, 0, 1, 1'b0});
        send_bits(0, frame8(8'h3C, 1'b0), 10);
        idle_bits(2);

        // break: 10 low bit times, then 0x55 after idle
        brk_before = brk_cnt_a;
        send_bits(0, 16'h0000, 10);
        idle_bits(2);
        check("a_brk_pulses", brk_cnt_a - brk_before, 1);
        check("a_brk_no_valid", int'(vld_a), 0);
        q_a.push_back('{32'h55, 0, 0, 1'b0});
        send_bits(0, frame8(8'h55, 1'b1), 10);
        idle_bits(2);

        // overrun: 0x11 held, 0x22 dropped
        rdy_a = 1'b0;
        q_a.push_back('{32'h11, 0, 0, 1'b0});
        send_bits(0, frame8(8'h11, 1'b1), 10);
        idle_bits(1);
        check("a_ovr_before", int'(ovr_a), 0);
        send_bits(0, frame8(8'h22, 1'b1), 10);
        idle_bits(1);
        #1;
        check("a_ovr_hold_valid", int'(vld_a), 1);
        check("a_ovr_hold_data", int'(data_a), 'h11);
        check("a_ovr_set", int'(ovr_a), 1);
        @(negedge clk);
        rdy_a = 1'b1;
        @(negedge clk);
        #1;
        check("a_ovr_consumed", int'(vld_a), 0);
        check("a_ovr_sticky", int'(ovr_a), 1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        #1;
        check("a_ovr_cleared", int'(ovr_a), 0);

        // glitch: 4 cycles low, then 0x7E
        @(negedge clk);
        rxd_a = 1'b0;
        repeat (4) @(negedge clk);
        rxd_a = 1'b1;
        idle_bits(2);
        check("a_glitch_no_valid", int'(vld_a), 0);
        q_a.push_back('{32'h7E, 0, 0, 1'b0});
        send_bits(0, frame8(8'h7E, 1'b1), 10);
        idle_bits(2);

        // reset mid-frame of 0x99 (start + 4 data bits sent)
        send_bits(0, frame8(8'h99, 1'b1), 5);
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("mid_rst_valid", int'(vld_a), 0);
        check("mid_rst_data", int'(data_a), 0);
        check("mid_rst_flags", int'({par_a, frm_a, brk_a, ovr_a}), 0);
        @(negedge clk);
        n_reset = 1'b1;
        idle_bits(2);
        check("post_rst_no_valid", int'(vld_a), 0);
        q_a.push_back('{32'h42, 0, 0, 1'b0});
        send_bits(0, frame8(8'h42, 1'b1), 10);
        idle_bits(2);

        check("a_pending_words", q_a.size(), 0);
        check("b_pending_words", q_b.size(), 0);
        check("b_no_brk", brk_cnt_b, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
